// File: rtl/wt_fetch_pkg.sv
// Shared types and constants for the layer-2 weight ROM fetch sequencer.
package wt_fetch_pkg;

  localparam int ADDR_WIDTH  = 7;
  localparam int DATA_WIDTH  = 144;
  localparam int DEPTH       = 76;
  localparam int WT_WIDTH    = 16;
  localparam int WT_PER_WORD = DATA_WIDTH / WT_WIDTH;
  localparam int PAIR_STRIDE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] wt_b;
    logic [DATA_WIDTH-1:0] wt_a;
  } pair_t;

endpackage

// File: rtl/wt_fetch_fifo2.sv
// Two-entry first-word-fall-through FIFO of weight pairs; the head is always
// visible on rd_data, and storage resets to zero so the idle head reads as 0.
module wt_fetch_fifo2
  import wt_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  pair_t      wr_data,
  input  logic       pop,
  output pair_t      rd_data,
  output logic [1:0] count
);

  pair_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  pop_eff;

  assign pop_eff = pop && (count != 2'd0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_eff) rd_ptr <= ~rd_ptr;
      case ({push, pop_eff})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wt_fetch2.sv
// Layer-2 weight ROM read sequencer: walks a word range two words per cycle and
// streams word pairs out over valid/ready. Optional WT_FETCH2_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | address presented; ROM reads issued as buffer credit allows
// DRAIN | all reads issued; waiting for in-flight data and buffer to empty
module wt_fetch2
  import wt_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_pairs,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_wt_a,
  output logic [DATA_WIDTH-1:0] out_wt_b,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(PAIR_STRIDE);

  state_t                state;
  logic [ADDR_WIDTH-1:0] num_r;
  logic [ADDR_WIDTH-1:0] issued;
  logic                  q_v;
  logic                  q_last;
  logic [1:0]            fifo_count;
  pair_t                 wr_pair;
  pair_t                 head;
  logic                  pop;
  logic                  credit;
  logic                  drain_empty;
  logic                  reject;
  logic [2:0]            outstanding;
  logic [2:0]            limit;

  // q_v marks a ROM read whose data lands on q_a/q_b this cycle.
  assign pop         = out_valid && out_ready;
  assign outstanding = {1'b0, fifo_count} + {2'b00, q_v};
  assign limit       = 3'd2 + {2'b00, pop};
  assign credit      = outstanding < limit;
  assign drain_empty = !q_v && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

`ifdef WT_FETCH2_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH+1:0] DEPTH_EXT = (ADDR_WIDTH+2)'(DEPTH);
  logic [ADDR_WIDTH+1:0] end_addr;
  assign end_addr = {2'b00, base_addr} + {1'b0, num_pairs, 1'b0};
  assign reject   = base_addr[0] || (end_addr > DEPTH_EXT);
`else
  assign reject   = 1'b0;
`endif

  assign wr_pair = '{last: q_last, wt_b: q_b, wt_a: q_a};

  wt_fetch_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (q_v),
    .wr_data (wr_pair),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_wt_a  = head.wt_a;
  assign out_wt_b  = head.wt_b;
  assign out_last  = head.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_a <= '0;
      addr_b <= ADDR_WIDTH'(1);
      num_r  <= '0;
      issued <= '0;
      q_v    <= 1'b0;
      q_last <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      q_v  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (reject) begin
              err <= 1'b1;
            end else if (num_pairs == '0) begin
              done <= 1'b1;
            end else begin
              num_r  <= num_pairs;
              issued <= '0;
              addr_a <= base_addr;
              addr_b <= base_addr + ADDR_WIDTH'(1);
              busy   <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          // Issue only when the pair can be guaranteed a buffer slot.
          if (credit) begin
            q_v    <= 1'b1;
            q_last <= (issued == num_r - ADDR_WIDTH'(1));
            issued <= issued + ADDR_WIDTH'(1);
            addr_a <= addr_a + STRIDE;
            addr_b <= addr_b + STRIDE;
            if (issued + ADDR_WIDTH'(1) == num_r) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_fetch2.sv
// Directed self-checking bench for wt_fetch2 with a behavioural dual-port ROM.
module tb_wt_fetch2;
  import wt_fetch_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] num_pairs;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_wt_a;
  logic [DATA_WIDTH-1:0] out_wt_b;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  err;

  int n_checks = 0;
  int n_errors = 0;

  wt_fetch2 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_pairs (num_pairs),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wt_a  (out_wt_a),
    .out_wt_b  (out_wt_b),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Every word is distinct: weight k of word a holds {a, k}.
  function automatic logic [DATA_WIDTH-1:0] rom_word(input int a);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < WT_PER_WORD; k++)
      w[16*k +: 16] = 16'(((a & 127) << 4) | k);
    return w;
  endfunction

  always @(posedge clk) begin
    q_a <= rom_word(int'(addr_a));
    q_b <= rom_word(int'(addr_b));
  end

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] got,
                     input logic [DATA_WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one command and checks every transferred pair against the ROM model.
  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 repeating.
  // poke_cyc >= 0 raises a second start in that cycle, which must be ignored.
  task automatic run_cmd(input int base, input int n, input int mode,
                         input int poke_cyc, output int done_cyc, output int last_xfer);
    int got;
    int first_cyc;
    int issued;
    logic held;
    logic [DATA_WIDTH-1:0] hold_a;
    logic hold_last;
    got = 0; first_cyc = -1; held = 1'b0; hold_a = '0; hold_last = 1'b0;
    done_cyc = -1; last_xfer = -1;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_WIDTH'(base); num_pairs = ADDR_WIDTH'(n);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) begin
      chk("addr_a_start", 144'(addr_a), 144'(base & 127));
      chk("addr_b_start", 144'(addr_b), 144'((base + 1) & 127));
      chk("busy_start", 144'(busy), 144'(1));
    end
    for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
      if (cyc == poke_cyc) begin
        start = 1'b1; base_addr = 7'd40; num_pairs = 7'd1;
      end else begin
        start = 1'b0;
      end
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      issued = ((int'(addr_a) - base) & 127) >> 1;
      if (n > 0 && issued - got > 2) chk("buffer_bound", 144'(issued - got), 144'(2));
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held) begin
          chk("stall_stable_a", out_wt_a, hold_a);
          chk("stall_stable_last", 144'(out_last), 144'(hold_last));
        end
        if (out_ready) begin
          chk("pair_a", out_wt_a, rom_word(base + 2 * got));
          chk("pair_b", out_wt_b, rom_word(base + 2 * got + 1));
          chk("pair_last", 144'(out_last), 144'(got == n - 1));
          got++;
          held = 1'b0;
          last_xfer = cyc;
        end else begin
          held = 1'b1; hold_a = out_wt_a; hold_last = out_last;
        end
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", 144'(busy), 144'(0));
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("pair_count", 144'(got), 144'(n));
    if (n > 0) begin
      chk("first_valid_cyc", 144'(first_cyc), 144'(2));
      chk("done_after_last", 144'(done_cyc), 144'(last_xfer + 1));
    end else begin
      chk("zero_done_cyc", 144'(done_cyc), 144'(0));
      chk("zero_no_valid", 144'(first_cyc), 144'(-1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr_a"}, 144'(addr_a), 144'(0));
    chk({tag, "_addr_b"}, 144'(addr_b), 144'(1));
    chk({tag, "_valid"}, 144'(out_valid), 144'(0));
    chk({tag, "_wt_a"}, out_wt_a, 144'(0));
    chk({tag, "_wt_b"}, out_wt_b, 144'(0));
    chk({tag, "_last"}, 144'(out_last), 144'(0));
    chk({tag, "_busy"}, 144'(busy), 144'(0));
    chk({tag, "_done"}, 144'(done), 144'(0));
    chk({tag, "_err"}, 144'(err), 144'(0));
  endtask

  initial begin
    int dc;
    int lx;
    int got;
    int saw_done;
    logic [ADDR_WIDTH-1:0] a_before;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_pairs = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst");

    // Basic 3-pair fetch, ready held high: last transfer 4 cycles after E0.
    run_cmd(0, 3, 0, -1, dc, lx);
    chk("t1_last_xfer_cyc", 144'(lx), 144'(4));
    chk("t1_done_cyc", 144'(dc), 144'(5));

    // Toggling ready.
    run_cmd(10, 4, 1, -1, dc, lx);

    // Zero-length command.
    run_cmd(20, 0, 0, -1, dc, lx);

    // Second start during FETCH is ignored.
    run_cmd(30, 4, 0, 1, dc, lx);

    // Reset after the second transfer of an 8-pair command.
    @(negedge clk);
    start = 1'b1; base_addr = 7'd50; num_pairs = 7'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      if (out_valid && out_ready) got++;
      @(negedge clk);
    end
    chk("rst_mid_xfers", 144'(got), 144'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_mid");
    saw_done = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done || out_valid) saw_done = 1;
      @(negedge clk);
    end
    chk("rst_mid_quiet", 144'(saw_done), 144'(0));
    run_cmd(0, 1, 0, -1, dc, lx);

`ifdef WT_FETCH2_RANGE_CHECK_EN
    // Range overflow: 74 + 4 > 76.
    a_before = addr_a;
    @(negedge clk);
    start = 1'b1; base_addr = 7'd74; num_pairs = 7'd2;
    @(negedge clk);
    start = 1'b0;
    chk("rc_over_err", 144'(err), 144'(1));
    chk("rc_over_busy", 144'(busy), 144'(0));
    chk("rc_over_addr", 144'(addr_a), 144'(a_before));
    @(negedge clk);
    chk("rc_over_err_pulse", 144'(err), 144'(0));
    chk("rc_over_done", 144'(done), 144'(0));
    // Odd base.
    start = 1'b1; base_addr = 7'd3; num_pairs = 7'd1;
    @(negedge clk);
    start = 1'b0;
    chk("rc_odd_err", 144'(err), 144'(1));
    chk("rc_odd_busy", 144'(busy), 144'(0));
    // Exactly reaching the end is accepted.
    run_cmd(74, 1, 0, -1, dc, lx);
`else
    a_before = addr_a;
    chk("no_rc_err_idle", 144'(err), 144'(0));
    run_cmd(124, 3, 0, -1, dc, lx);
    chk("wrap_addr_a", 144'(addr_a), 144'(2));
    chk("wrap_addr_b", 144'(addr_b), 144'(3));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
